password_programmer: RTL and testbench
======================================

Name: password_programmer

Overview:
Writer side of the 4-digit password memory that the access controller reads through its 4-bit data / 2-bit address port. The programmer is enabled only while the system is unlocked (green state). The user keys a new 4-digit BCD password on the switches, then re-keys it to confirm, and the block commits it to the password RAM as a 4-word write burst. It sits between the button shaper, the switches and the password RAM write port. Its busy output gates the check button to the access controller.

Parameters:
DIGITS, 4, number of password digits (RAM depth; fixed at 4 for 2-bit address)
DATA_W, 4, digit width (BCD)
TIMEOUT_CYC, 250000000, idle cycles allowed between presses in ENTER/CONFIRM (5 s @ 50 MHz); bench overrides to 20
HOLD_CYC, 50000000, cycles DONE/ERROR indication is held before returning to IDLE; bench overrides to 8

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-low reset (0 = reset)
bt_prog  in  1  program-request button from button shaper, active-low, low for exactly one clk per press
bt_enter  in  1  digit-enter button from button shaper, active-low, one-clk low pulse
sw_digit  in  4  digit on switches, sampled on the bt_enter pulse
unlocked  in  1  1 while the access controller is in its unlocked state
ram_addr  out  2  password RAM write address
ram_data  out  4  password RAM write data
ram_wren  out  1  password RAM write enable, active-high
led_prog  out  2  {green,red}: 00 idle, 11 entering/confirming, 10 done, 01 error
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; idx=0; timer=0; mismatch=0; buffer words=0; ram_addr=0; ram_data=0; ram_wren=0; led_prog=00; busy=0. Reset mid-burst aborts the burst; the RAM may hold a partial write.
- All outputs are registered. A press is acted on in the cycle it is sampled low; the result is visible the next cycle.
- IDLE: bt_prog=0 and unlocked=1 -> ENTER, idx=0, timer=0. bt_prog while unlocked=0 is ignored. bt_enter is ignored. If bt_prog and bt_enter are low in the same cycle, bt_prog wins and the digit is not counted.
- ENTER: on bt_enter=0:
  - sw_digit>9 -> ERROR.
  - Otherwise buf[idx]<=sw_digit, idx++, timer=0.
  - After the 4th digit (idx==3): -> CONFIRM, idx=0, mismatch=0.
- CONFIRM: on bt_enter=0: if sw_digit!=buf[idx], mismatch=1; idx++, timer=0. All 4 digits are always consumed, with no early exit. After the 4th digit: (mismatch or 4th digit mismatches) ? ERROR : WRITE, idx=0.
- ENTER/CONFIRM common rules:
  - timer increments every cycle without a press; timer==TIMEOUT_CYC-1 -> ERROR.
  - unlocked=0 -> IDLE immediately, buffer discarded, no RAM write.
  - bt_prog is ignored.
- WRITE: 4 consecutive cycles with ram_wren=1, ram_addr=idx, ram_data=buf[idx] for idx=0..3. Atomic: unlocked, bt_prog and bt_enter are ignored. After idx 3 -> DONE; ram_wren=0, ram_addr=0, ram_data=0 the next cycle.
- DONE: led_prog=10; timer counts to HOLD_CYC-1, then -> IDLE.
- ERROR: led_prog=01; timer counts to HOLD_CYC-1, then -> IDLE. The RAM is untouched.
- Outside WRITE: ram_wren=0, ram_addr=0, ram_data=0.
- idx is 2 bits and wraps 3->0 only on the explicit transitions above. timer is 28 bits and saturation is never reached.

Test Plan:
- Reset low mid-ENTER, asynchronously between clock edges -> all outputs zero immediately, state IDLE, busy=0.
- unlocked=1, bt_prog pulse, enter 2,0,2,5, confirm 2,0,2,5 -> led_prog 11 during entry; 4 cycles ram_wren=1 with (addr,data)=(0,2),(1,0),(2,2),(3,5); then led_prog=10 for 8 cycles; then idle with busy=0.
- Enter 1,2,3,4, confirm 1,2,9,4 -> ERROR after the 4th confirm press, ram_wren never asserted, led_prog=01 for 8 cycles.
- Enter 1, then sw_digit=12 press -> ERROR immediately, no write.
- After 2 digits, no press for 20 cycles -> ERROR. Separately, unlocked dropped during CONFIRM -> IDLE next cycle, no write.
- unlocked=0 with bt_prog pulse -> stays IDLE. In IDLE, bt_prog and bt_enter low together with unlocked=1 -> ENTER with idx=0; drop unlocked mid-WRITE -> all 4 writes still complete.

Source files
------------

// File: rtl/password_programmer_if.sv
// password_programmer_if: button/switch inputs and password RAM write port of the programmer.
interface password_programmer_if #(
    parameter int DATA_W = 4
);
    logic              bt_prog;
    logic              bt_enter;
    logic [DATA_W-1:0] sw_digit;
    logic              unlocked;
    logic [1:0]        ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [1:0]        led_prog;
    logic              busy;

    modport master (
        output bt_prog, bt_enter, sw_digit, unlocked,
        input  ram_addr, ram_data, ram_wren, led_prog, busy
    );

    modport slave (
        input  bt_prog, bt_enter, sw_digit, unlocked,
        output ram_addr, ram_data, ram_wren, led_prog, busy
    );
endinterface

// File: rtl/password_programmer.sv
// password_programmer: collects a 4-digit BCD password twice and, if both entries agree,
// writes it to the password RAM as a 4-word burst.
module password_programmer #(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 250000000,
    parameter int HOLD_CYC    = 50000000
) (
    input logic                clk,
    input logic                reset,
    password_programmer_if.slave pif
);
    typedef enum logic [2:0] {IDLE, ENTER, CONFIRM, WRITE, DONE, ERROR} state_t;

    localparam logic [27:0] TO_LAST   = 28'(TIMEOUT_CYC - 1);
    localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [27:0]       timer_q, timer_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] buf_q [DIGITS];
    logic [DATA_W-1:0] buf_d [DIGITS];
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic [1:0]        led_q, led_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        mis_d   = mis_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (!pif.bt_prog && pif.unlocked) begin
                state_d = ENTER;
                idx_d   = 2'd0;
                timer_d = 28'd0;
            end
            ENTER, CONFIRM: begin
                timer_d = timer_q + 28'd1;
                if (!pif.unlocked) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    timer_d = 28'd0;
                    mis_d   = 1'b0;
                    buf_d   = '{default: '0};
                end else if (!pif.bt_enter) begin
                    timer_d = 28'd0;
                    idx_d   = idx_q + 2'd1;
                    if (state_q == ENTER) begin
                        if (pif.sw_digit > DATA_W'(9)) begin
                            state_d = ERROR;
                            idx_d   = 2'd0;
                        end else begin
                            buf_d[idx_q] = pif.sw_digit;
                            if (idx_q == 2'd3) begin
                                state_d = CONFIRM;
                                mis_d   = 1'b0;
                            end
                        end
                    end else begin
                        // every confirm digit is consumed; the verdict comes only after the 4th
                        mis_d = mis_q | (pif.sw_digit != buf_q[idx_q]);
                        if (idx_q == 2'd3) state_d = mis_d ? ERROR : WRITE;
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d = ERROR;
                    idx_d   = 2'd0;
                    timer_d = 28'd0;
                end
            end
            WRITE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    timer_d = 28'd0;
                end
            end
            DONE, ERROR: begin
                timer_d = timer_q + 28'd1;
                if (timer_q == HOLD_LAST) begin
                    state_d = IDLE;
                    timer_d = 28'd0;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered, so they are derived from the next state
        wren_d = state_d == WRITE;
        addr_d = wren_d ? idx_d : 2'd0;
        data_d = wren_d ? buf_q[idx_d] : '0;
        led_d  = (state_d == ENTER || state_d == CONFIRM || state_d == WRITE) ? 2'b11 :
                 state_d == DONE ? 2'b10 : state_d == ERROR ? 2'b01 : 2'b00;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            timer_q <= 28'd0;
            mis_q   <= 1'b0;
            buf_q   <= '{default: '0};
            addr_q  <= 2'd0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            led_q   <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            mis_q   <= mis_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign pif.ram_addr = addr_q;
    assign pif.ram_data = data_q;
    assign pif.ram_wren = wren_q;
    assign pif.led_prog = led_q;
    assign pif.busy     = busy_q;
endmodule

// File: tb/tb_password_programmer.sv
// tb_password_programmer: directed and randomized password entry against a
// behavioural outcome model (valid digits + identical confirm -> 4 writes, else error).
module tb_password_programmer;
    localparam int TO   = 20;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    int   stray   = 0;
    logic [5:0] wq[$];

    password_programmer_if pif ();

    password_programmer #(.TIMEOUT_CYC(TO), .HOLD_CYC(HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .pif  (pif)
    );

    always #5 clk = ~clk;

    // write port monitor: records every RAM write, flags nonzero addr/data while idle
    always @(negedge clk) begin
        if (reset) begin
            if (pif.ram_wren) wq.push_back({pif.ram_addr, pif.ram_data});
            else if (pif.ram_addr != 2'd0 || pif.ram_data != 4'd0) stray++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_prog();
        pif.bt_prog = 1'b0;
        @(negedge clk);
        pif.bt_prog = 1'b1;
    endtask

    task automatic press_enter(input logic [3:0] d);
        pif.sw_digit = d;
        pif.bt_enter = 1'b0;
        @(negedge clk);
        pif.bt_enter = 1'b1;
    endtask

    task automatic hold_check(input string tag, input logic [1:0] led);
        chk({tag, "_led_first"}, 32'(pif.led_prog), 32'(led));
        step(HOLD - 1);
        chk({tag, "_led_last"}, 32'(pif.led_prog), 32'(led));
        step(1);
        chk({tag, "_idle_led"}, 32'(pif.led_prog), 0);
        chk({tag, "_idle_busy"}, 32'(pif.busy), 0);
    endtask

    task automatic check_writes(input string tag, input logic [3:0] e [4]);
        chk({tag, "_wr_count"}, 32'(wq.size()), 4);
        for (int i = 0; i < 4; i++)
            chk({tag, "_wr"}, 32'(i < wq.size() ? wq[i] : 6'h3f), 32'({2'(i), e[i]}));
    endtask

    task automatic run_txn(input string tag, input logic [3:0] e [4], input logic [3:0] c [4], input int gap);
        bit same;
        wq.delete();
        press_prog();
        chk({tag, "_prog_led"}, 32'(pif.led_prog), 3);
        chk({tag, "_prog_busy"}, 32'(pif.busy), 1);
        for (int i = 0; i < 4; i++) begin
            step(gap);
            press_enter(e[i]);
            if (e[i] > 4'd9) begin
                hold_check({tag, "_bad"}, 2'b01);
                chk({tag, "_bad_nowr"}, 32'(wq.size()), 0);
                return;
            end
        end
        chk({tag, "_entered_led"}, 32'(pif.led_prog), 3);
        for (int i = 0; i < 4; i++) begin
            step(gap);
            press_enter(c[i]);
        end
        same = 1'b1;
        for (int i = 0; i < 4; i++) if (c[i] != e[i]) same = 1'b0;
        if (same) begin
            step(4);
            check_writes(tag, e);
            hold_check({tag, "_done"}, 2'b10);
        end else begin
            hold_check({tag, "_err"}, 2'b01);
            chk({tag, "_err_nowr"}, 32'(wq.size()), 0);
        end
    endtask

    initial begin
        logic [3:0] e [4];
        logic [3:0] c [4];
        int r, k;
        pif.bt_prog  = 1'b1;
        pif.bt_enter = 1'b1;
        pif.sw_digit = 4'd0;
        pif.unlocked = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_led", 32'(pif.led_prog), 0);
        chk("rst_busy", 32'(pif.busy), 0);
        chk("rst_wren", 32'(pif.ram_wren), 0);
        chk("rst_addr", 32'(pif.ram_addr), 0);
        chk("rst_data", 32'(pif.ram_data), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1);

        // asynchronous reset in the middle of entry
        press_prog();
        press_enter(4'd3);
        chk("mid_enter_led", 32'(pif.led_prog), 3);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_led", 32'(pif.led_prog), 0);
        chk("async_rst_busy", 32'(pif.busy), 0);
        @(negedge clk);
        reset = 1'b1;
        step(2);
        chk("post_rst_busy", 32'(pif.busy), 0);

        e = '{4'd2, 4'd0, 4'd2, 4'd5};
        run_txn("p2025", e, e, 0);
        e = '{4'd1, 4'd2, 4'd3, 4'd4};
        c = '{4'd1, 4'd2, 4'd9, 4'd4};
        run_txn("mism", e, c, 1);
        e = '{4'd1, 4'd12, 4'd0, 4'd0};
        run_txn("bcd", e, e, 0);

        // inactivity timeout after two digits
        press_prog();
        press_enter(4'd4);
        press_enter(4'd5);
        step(TO - 1);
        chk("to_before", 32'(pif.led_prog), 3);
        step(1);
        hold_check("to", 2'b01);

        // losing unlock during confirm abandons the entry
        wq.delete();
        press_prog();
        for (int i = 1; i <= 4; i++) press_enter(4'(i));
        press_enter(4'd1);
        pif.unlocked = 1'b0;
        step(1);
        chk("unl_led", 32'(pif.led_prog), 0);
        chk("unl_busy", 32'(pif.busy), 0);
        pif.unlocked = 1'b1;
        step(2);
        chk("unl_nowr", 32'(wq.size()), 0);

        // program request while locked
        pif.unlocked = 1'b0;
        press_prog();
        chk("locked_busy", 32'(pif.busy), 0);
        step(3);
        chk("locked_busy2", 32'(pif.busy), 0);
        pif.unlocked = 1'b1;

        // prog and enter together: digit not counted; unlock loss mid-write ignored
        wq.delete();
        pif.sw_digit = 4'd7;
        pif.bt_prog  = 1'b0;
        pif.bt_enter = 1'b0;
        @(negedge clk);
        pif.bt_prog  = 1'b1;
        pif.bt_enter = 1'b1;
        chk("both_led", 32'(pif.led_prog), 3);
        e = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) press_enter(e[i]);
        for (int i = 0; i < 4; i++) press_enter(e[i]);
        pif.unlocked = 1'b0;
        step(4);
        check_writes("atomic", e);
        hold_check("atomic_done", 2'b10);
        pif.unlocked = 1'b1;

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4; i++) e[i] = 4'($urandom_range(0, 9));
            c = e;
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 3);
            if (r < 4) c[k] = 4'((int'(e[k]) + 1 + $urandom_range(0, 8)) % 10);
            else if (r == 9) e[k] = 4'($urandom_range(10, 15));
            run_txn("rnd", e, c, $urandom_range(0, 3));
            step($urandom_range(0, 2));
        end
        chk("stray_outputs", 32'(stray), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
